pipe_stage_chain: RTL

Parametrised elastic pipeline-register chain: the successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers in the pipelined processor. It carries a WIDTH-bit payload through DEPTH register stages with valid/ready flow control and a skid buffer in every stage, so back-pressure never forms a combinational ready path across the chain. It also provides a synchronous flush for branch and exception squash, plus an occupancy count for hazard and debug logic.

---
 rtl/pipe_stage_chain.sv | 117 +++++++++++
 1 files changed

// File: rtl/pipe_stage_chain.sv
// Elastic pipeline-register chain: DEPTH skid-buffered stages with valid/ready
// flow control, synchronous flush and an occupancy count.

module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  input  logic             dn_ready
);
  logic             m_valid, s_valid;
  logic [WIDTH-1:0] m_data, s_data;
  logic             up_xfer, dn_take;

  // Ready comes straight off the skid flag, so stall never ripples combinationally upstream.
  assign up_ready = !s_valid;
  assign up_xfer  = up_valid && !s_valid;
  assign dn_take  = m_valid && dn_ready;
  assign dn_valid = m_valid;
  assign dn_data  = m_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (dn_take) begin
      if (s_valid) begin
        m_data  <= s_data;
        s_valid <= 1'b0;
      end else if (up_xfer) begin
        m_data  <= up_data;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (!m_valid) begin
      if (up_xfer) begin
        m_valid <= 1'b1;
        m_data  <= up_data;
      end
    end else if (up_xfer) begin
      // main is stuck: park the incoming item in the skid slot
      s_valid <= 1'b1;
      s_data  <= up_data;
    end
  end
endmodule

module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             empty
);
  // Index 0 is the input port side, index DEPTH the output port side.
  logic [DEPTH:0]            vld;
  logic [DEPTH:0]            rdy;
  logic [DEPTH:0][WIDTH-1:0] dat;
  logic                      in_xfer, out_xfer;

  assign vld[0]     = in_valid;
  assign dat[0]     = in_data;
  assign rdy[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .up_valid (vld[k]),
      .up_data  (dat[k]),
      .up_ready (rdy[k]),
      .dn_valid (vld[k+1]),
      .dn_data  (dat[k+1]),
      .dn_ready (rdy[k+1])
    );
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = vld[DEPTH] && !flush;
  assign out_data  = dat[DEPTH];
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign empty     = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (flush)
      count <= '0;
    else if (in_xfer && !out_xfer)
      count <= count + CW'(1);
    else if (!in_xfer && out_xfer)
      count <= count - CW'(1);
  end
endmodule
